// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the EX stage and the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       alucontrol;
  logic             start;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             ready;
  logic             stall;

  modport master (
    output alucontrol, start, annul, a, b,
    input  hi, lo, ready, stall
  );

  modport slave (
    input  alucontrol, start, annul, a, b,
    output hi, lo, ready, stall
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV / DIVU.
// Quotient goes to lo, remainder to hi; stalls the pipeline while busy.
//
// state  | meaning
// IDLE   | waiting for a div op; accept is combinational and raises stall
// BUSY   | one shift/trial-subtract step per edge, WIDTH steps in total
// DONE   | result held in hi/lo, ready pulse, back to IDLE next edge
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  localparam int         CW          = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_a_orig;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_signed;
  logic             r_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_div;
  logic             w_signed_op;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quot_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_is_div    = (bus.alucontrol == EXE_DIV_OP) || (bus.alucontrol == EXE_DIVU_OP);
  assign w_signed_op = (bus.alucontrol == EXE_DIV_OP);
  assign w_accept    = (r_state == S_IDLE) && bus.start && w_is_div && !bus.annul;
  assign w_last      = (r_state == S_BUSY) && (r_cnt == LAST_ITER);

  assign w_a_abs = (w_signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_abs = (w_signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Remainder stays below the divisor, so WIDTH+1 bits of shifted remainder
  // plus one guard bit are enough to read the trial sign.
  assign w_shift    = {r_rem, r_quot[WIDTH-1]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_ge       = ~w_trial[WIDTH+1];
  assign w_rem_nxt  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};

  // Remainder follows the dividend's sign; quotient negated on sign mismatch.
  assign w_q_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? -w_quot_nxt : w_quot_nxt;
  assign w_r_fix = (r_signed && r_sign_a) ? -w_rem_nxt : w_rem_nxt;

  assign bus.stall = w_accept || (r_state == S_BUSY);
  assign bus.ready = (r_state == S_DONE) && !bus.annul;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; annul drops any operation in flight
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (bus.annul)   w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration counter: runs while BUSY, cleared otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state == S_BUSY) r_cnt <= r_cnt + 1'b1;
    else                        r_cnt <= '0;
  end

  // Operand capture on accept, then one restoring step per BUSY edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_a_orig  <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_signed  <= 1'b0;
      r_zero    <= 1'b0;
    end else if (w_accept) begin
      r_rem     <= '0;
      r_quot    <= w_a_abs;
      r_divisor <= w_b_abs;
      r_a_orig  <= bus.a;
      r_sign_a  <= bus.a[WIDTH-1];
      r_sign_b  <= bus.b[WIDTH-1];
      r_signed  <= w_signed_op;
      r_zero    <= (bus.b == '0);
    end else if (r_state == S_BUSY) begin
      r_rem     <= w_rem_nxt;
      r_quot    <= w_quot_nxt;
    end
  end

  // Result registers: loaded on the final iteration unless annulled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_last && !bus.annul) begin
      r_hi <= r_zero ? r_a_orig : w_r_fix;
      r_lo <= r_zero ? '1       : w_q_fix;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic cases, latency, annul, reset, back-to-back.
module tb_div_unit;

  localparam logic [7:0] DIV  = 8'b00011010;
  localparam logic [7:0] DIVU = 8'b00011011;
  localparam logic [7:0] ADD  = 8'b00100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  div_unit_if #(.WIDTH(32)) bus();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division and watch 40 cycles: stall count, ready pulse position, result.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n_stall = 0;
    int n_ready = 0;
    int ready_at = -1;
    bus.alucontrol = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bus.stall) n_stall++;
      if (bus.ready) begin
        n_ready++;
        ready_at = i;
      end
      tick();
      if (i == 0) bus.start = 1'b0;
    end
    check({tag, "_stall_cycles"}, n_stall, 33);
    check({tag, "_ready_pulses"}, n_ready, 1);
    check({tag, "_ready_cycle"}, ready_at, 33);
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_hi"}, bus.hi, exp_hi);
  endtask

  initial begin
    int n_ready;
    int n_stall;
    int first_at;
    int second_at;
    logic stall_in_done;

    bus.alucontrol = 8'h00;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_ready", bus.ready, 1'b0);
    check("reset_stall", bus.stall, 1'b0);
    rst = 1'b0;
    tick();

    run_div("divu_ffff_2", DIVU, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'h00000001);
    run_div("div_7_2", DIV, 32'd7, 32'd2, 32'd3, 32'd1);
    run_div("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_div("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    run_div("divu_by0", DIVU, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678);
    run_div("div_by0", DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9);

    // Annul during iteration 10
    bus.alucontrol = DIVU;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.start = 1'b1;
    #1;
    check("annul10_accept_stall", bus.stall, 1'b1);
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.annul = 1'b1;
    tick();
    bus.annul = 1'b0;
    #1;
    check("annul10_idle_stall", bus.stall, 1'b0);
    n_ready = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) n_ready++;
      tick();
    end
    check("annul10_no_ready", n_ready, 0);
    check("annul10_lo_kept", bus.lo, 32'hFFFFFFFF);
    check("annul10_hi_kept", bus.hi, 32'hFFFFFFF9);

    run_div("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 32'd2);

    // Annul coincident with the final iteration edge
    bus.alucontrol = DIV;
    bus.a = 32'd7;
    bus.b = 32'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (31) tick();
    bus.annul = 1'b1;
    tick();
    bus.annul = 1'b0;
    #1;
    n_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ready) n_ready++;
      tick();
    end
    check("annul32_no_ready", n_ready, 0);
    check("annul32_lo_kept", bus.lo, 32'd14);
    check("annul32_hi_kept", bus.hi, 32'd2);

    // start together with annul in IDLE is not accepted
    bus.alucontrol = DIVU;
    bus.a = 32'd9;
    bus.b = 32'd3;
    bus.start = 1'b1;
    bus.annul = 1'b1;
    #1;
    check("start_annul_stall", bus.stall, 1'b0);
    tick();
    check("start_annul_stall_next", bus.stall, 1'b0);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    tick();

    // Back-to-back with start held through DONE
    bus.alucontrol = DIVU;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.start = 1'b1;
    #1;
    n_ready = 0;
    first_at = -1;
    second_at = -1;
    stall_in_done = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (bus.ready) begin
        n_ready++;
        if (n_ready == 1) begin
          first_at = i;
          stall_in_done = bus.stall;
        end
        if (n_ready == 2) begin
          second_at = i;
          bus.start = 1'b0;
        end
      end
      tick();
    end
    check("b2b_ready_pulses", n_ready, 2);
    check("b2b_first_ready", first_at, 33);
    check("b2b_gap", second_at - first_at, 34);
    check("b2b_done_stall", stall_in_done, 1'b0);
    check("b2b_lo", bus.lo, 32'd14);
    check("b2b_hi", bus.hi, 32'd2);

    // Asynchronous reset mid-BUSY
    bus.alucontrol = DIVU;
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy_stall", bus.stall, 1'b0);
    check("rst_busy_ready", bus.ready, 1'b0);
    check("rst_busy_hi", bus.hi, 32'h0);
    check("rst_busy_lo", bus.lo, 32'h0);
    tick();
    rst = 1'b0;

    // Non-div op never starts the unit
    bus.alucontrol = ADD;
    bus.a = 32'd5;
    bus.b = 32'd3;
    bus.start = 1'b1;
    #1;
    check("add_stall", bus.stall, 1'b0);
    n_stall = 0;
    n_ready = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.stall) n_stall++;
      if (bus.ready) n_ready++;
      tick();
    end
    check("add_no_stall", n_stall, 0);
    check("add_no_ready", n_ready, 0);
    check("add_lo_zero", bus.lo, 32'h0);
    bus.start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
